// File: rtl/mdu_pkg.sv
// +----------------------------------------------------------------------------+
// | mdu_pkg : op encoding and default latencies for the multiply/divide unit.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package mdu_pkg;

    typedef logic [2:0] mdu_op_t;

    localparam mdu_op_t MDU_NONE  = 3'd0;
    localparam mdu_op_t MDU_MULT  = 3'd1;
    localparam mdu_op_t MDU_MULTU = 3'd2;
    localparam mdu_op_t MDU_DIV   = 3'd3;
    localparam mdu_op_t MDU_DIVU  = 3'd4;
    localparam mdu_op_t MDU_MTHI  = 3'd5;
    localparam mdu_op_t MDU_MTLO  = 3'd6;

    localparam int C_MULT_CYCLES = 5;
    localparam int C_DIV_CYCLES  = 10;

endpackage

`default_nettype wire

// File: rtl/mdu_if.sv
// +----------------------------------------------------------------------------+
// | mdu_if : request/result bundle between the execute stage and the MDU.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface mdu_if;
    import mdu_pkg::*;

    logic        start;
    mdu_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, a, b, input  busy, hi, lo);
    modport slave  (input  start, op, a, b, output busy, hi, lo);

endinterface

`default_nettype wire

// File: rtl/mdu.sv
// +----------------------------------------------------------------------------+
// | mdu : fixed-latency multiply/divide unit owning the HI/LO registers.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = C_MULT_CYCLES,
    parameter int DIV_CYCLES  = C_DIV_CYCLES
) (
    input  wire     clk,
    input  wire     reset,
    mdu_if.slave    bus
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_pend_hi;
    logic [31:0]      r_pend_lo;
    logic             r_pend_wr;

    logic [63:0]        w_sprod;
    logic [63:0]        w_uprod;
    logic signed [32:0] w_sa;
    logic signed [32:0] w_sb;
    logic [31:0]        w_b_safe;
    logic [31:0]        w_squot;
    logic [31:0]        w_srem;
    logic [31:0]        w_uquot;
    logic [31:0]        w_urem;
    logic               w_b_zero;

    assign w_sprod  = {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b};
    assign w_uprod  = {32'd0, bus.a} * {32'd0, bus.b};

    // A zero divisor is replaced so the dividers stay well defined; the result is discarded anyway.
    assign w_b_zero = (bus.b == 32'd0);
    assign w_b_safe = w_b_zero ? 32'd1 : bus.b;

    // 33-bit signed operands keep 0x80000000 / -1 representable before truncation.
    assign w_sa     = {bus.a[31], bus.a};
    assign w_sb     = {w_b_safe[31], w_b_safe};
    assign w_squot  = 32'(w_sa / w_sb);
    assign w_srem   = 32'(w_sa % w_sb);
    assign w_uquot  = bus.a / w_b_safe;
    assign w_urem   = bus.a % w_b_safe;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_wr <= 1'b0;
        end else if (r_busy) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                r_busy <= 1'b0;
                if (r_pend_wr) begin
                    r_hi <= r_pend_hi;
                    r_lo <= r_pend_lo;
                end
            end
        end else if (bus.start) begin
            case (bus.op)
                MDU_MULT: begin
                    {r_pend_hi, r_pend_lo} <= w_sprod;
                    r_pend_wr <= 1'b1;
                    r_cnt     <= CNT_W'(MULT_CYCLES);
                    r_busy    <= 1'b1;
                end
                MDU_MULTU: begin
                    {r_pend_hi, r_pend_lo} <= w_uprod;
                    r_pend_wr <= 1'b1;
                    r_cnt     <= CNT_W'(MULT_CYCLES);
                    r_busy    <= 1'b1;
                end
                MDU_DIV: begin
                    r_pend_hi <= w_srem;
                    r_pend_lo <= w_squot;
                    r_pend_wr <= !w_b_zero;
                    r_cnt     <= CNT_W'(DIV_CYCLES);
                    r_busy    <= 1'b1;
                end
                MDU_DIVU: begin
                    r_pend_hi <= w_urem;
                    r_pend_lo <= w_uquot;
                    r_pend_wr <= !w_b_zero;
                    r_cnt     <= CNT_W'(DIV_CYCLES);
                    r_busy    <= 1'b1;
                end
                MDU_MTHI: r_hi <= bus.a;
                MDU_MTLO: r_lo <= bus.a;
                default: ;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mdu.sv
// +----------------------------------------------------------------------------+
// | tb_mdu : directed and random checks of mdu against an arithmetic model.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mdu;
    import mdu_pkg::*;

    localparam int C_MC = 5;
    localparam int C_DC = 10;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_miss = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_if bus ();

    mdu #(.MULT_CYCLES(C_MC), .DIV_CYCLES(C_DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural result from plain 64-bit arithmetic; wr=0 means HI/LO keep their value.
    task automatic ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              output logic [31:0] rh, output logic [31:0] rl, output bit wr);
        longint     sq, sr;
        logic [63:0] p;
        wr = 1'b1;
        rh = m_hi;
        rl = m_lo;
        case (op)
            MDU_MULT: begin
                sq = longint'($signed(a)) * longint'($signed(b));
                p  = sq;
                rh = p[63:32];
                rl = p[31:0];
            end
            MDU_MULTU: begin
                p  = {32'd0, a} * {32'd0, b};
                rh = p[63:32];
                rl = p[31:0];
            end
            MDU_DIV: begin
                if (b == 32'd0) wr = 1'b0;
                else begin
                    sq = longint'($signed(a)) / longint'($signed(b));
                    sr = longint'($signed(a)) % longint'($signed(b));
                    p  = sq; rl = p[31:0];
                    p  = sr; rh = p[31:0];
                end
            end
            MDU_DIVU: begin
                if (b == 32'd0) wr = 1'b0;
                else begin
                    rl = a / b;
                    rh = a % b;
                end
            end
            default: wr = 1'b0;
        endcase
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit interfere);
        logic [31:0] eh, el;
        bit          wr;
        int          n;
        n = (op == MDU_MULT || op == MDU_MULTU) ? C_MC :
            (op == MDU_DIV  || op == MDU_DIVU)  ? C_DC : 0;
        ref_result(op, a, b, eh, el, wr);
        if (op == MDU_MTHI) eh = a;
        if (op == MDU_MTLO) el = a;
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        tick();
        bus.start = 1'b0;
        if (n == 0) begin
            check("busy_nobusy", {31'd0, bus.busy}, 32'd0);
            check("hi_imm", bus.hi, eh);
            check("lo_imm", bus.lo, el);
        end else begin
            for (int i = 0; i < n; i++) begin
                check("busy_run", {31'd0, bus.busy}, 32'd1);
                check("hi_hold", bus.hi, m_hi);
                check("lo_hold", bus.lo, m_lo);
                bus.a = $urandom;
                bus.b = $urandom;
                if (interfere && i < 2) begin
                    bus.start = 1'b1;
                    bus.op    = (i == 0) ? MDU_MTLO : MDU_DIVU;
                end else begin
                    bus.start = 1'b0;
                end
                tick();
            end
            bus.start = 1'b0;
            check("busy_done", {31'd0, bus.busy}, 32'd0);
            check("hi_commit", bus.hi, wr ? eh : m_hi);
            check("lo_commit", bus.lo, wr ? el : m_lo);
            if (!wr) begin eh = m_hi; el = m_lo; end
        end
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        bus.start = 1'b0; bus.op = MDU_NONE; bus.a = 32'd0; bus.b = 32'd0;
        tick(); tick();
        reset = 1'b1;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);

        do_op(MDU_MULT,  32'hFFFF_FFFE, 32'd3, 1'b0);
        check("mult_hi", bus.hi, 32'hFFFF_FFFF);
        check("mult_lo", bus.lo, 32'hFFFF_FFFA);
        do_op(MDU_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("multu_hi", bus.hi, 32'h0000_0002);
        do_op(MDU_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_lo", bus.lo, 32'hFFFF_FFFD);
        check("div_hi", bus.hi, 32'hFFFF_FFFF);
        do_op(MDU_DIVU,  32'd7, 32'd2, 1'b0);
        check("divu_lo", bus.lo, 32'd3);
        do_op(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("divovf_lo", bus.lo, 32'h8000_0000);
        check("divovf_hi", bus.hi, 32'd0);

        do_op(MDU_MTHI, 32'h1234_5678, 32'd0, 1'b0);
        do_op(MDU_MTLO, 32'h9ABC_DEF0, 32'd0, 1'b0);
        check("mthi_val", bus.hi, 32'h1234_5678);
        do_op(MDU_DIV, 32'd55, 32'd0, 1'b0);
        check("div0_lo", bus.lo, 32'h9ABC_DEF0);

        do_op(MDU_MULT, 32'd6, 32'd7, 1'b1);
        check("mult67_lo", bus.lo, 32'd42);
        check("mult67_hi", bus.hi, 32'd0);
        do_op(MDU_DIVU, 32'd100, 32'd9, 1'b0);

        // Abort a divide with reset during its fourth busy cycle.
        bus.start = 1'b1; bus.op = MDU_DIVU; bus.a = 32'd1000; bus.b = 32'd3;
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick();
        check("abort_busy_pre", {31'd0, bus.busy}, 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_hi", bus.hi, 32'd0);
        check("abort_lo", bus.lo, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        for (int i = 0; i < C_DC + 2; i++) tick();
        check("abort_nocommit_lo", bus.lo, 32'd0);
        check("abort_nocommit_busy", {31'd0, bus.busy}, 32'd0);

        for (int k = 0; k < 40; k++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 20));
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            do_op(rop, ra, rb, bit'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mdu.md
# mdu

Multiply/divide unit for the MIPS core, sitting beside the ALU in the execute path and consuming the two register-file read operands (rs value, rt value). It executes mult, multu, div and divu over a fixed multi-cycle latency, owns the HI/LO architectural registers, and services mthi/mtlo writes. It raises `busy` so the controller can stall mfhi/mflo and any further MDU instruction until the result has committed.

## Interface

Parameters:
- `MULT_CYCLES`, 5, busy cycles for mult/multu (≥1)
- `DIV_CYCLES`, 10, busy cycles for div/divu (≥1)

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  synchronous, active-low reset: state clears on a rising edge where `reset`=0
- `start`  in  1  qualifies `op`; sampled every edge
- `op`  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved
- `a`  in  32  rs operand (dividend / multiplicand / mthi-mtlo source)
- `b`  in  32  rt operand (divisor / multiplier)
- `busy`  out  1  operation in flight
- `hi`  out  32  HI register
- `lo`  out  32  LO register

## Operation

- Idle (`busy`=0), `start`=1, op MULT/MULTU/DIV/DIVU: compute the result from `a`,`b` at that edge into pending registers, load counter with `MULT_CYCLES` or `DIV_CYCLES`, set `busy`.
- Busy: counter decrements each edge; on the edge where it goes 1→0, pending result commits to `hi`/`lo` and `busy` clears on the same edge.
- MULT: {hi,lo} = signed 64-bit a×b. MULTU: unsigned 64-bit product.
- DIV: lo = quotient truncated toward zero, hi = remainder with sign of dividend. 0x80000000 ÷ 0xFFFFFFFF → lo=0x80000000, hi=0x00000000.
- DIVU: unsigned quotient/remainder.
- Divide by zero (b=0): full `DIV_CYCLES` busy period still runs; `hi`/`lo` unchanged at commit.
- MTHI / MTLO with `start`=1 while idle: `hi`/`lo` ← `a` at that edge; `busy` stays 0; other register untouched.
- `start`=1 while `busy`=1 (any op): ignored entirely; in-flight op unaffected. The controller must stall instead; the block does not flag this.
- op NONE or 7 with `start`=1: no effect.
- Operands are latched at start; `a`/`b` changes during busy have no effect.

## Timing

- Reset (edge with `reset`=0): `busy`=0, `hi`=0, `lo`=0, counter=0, pending cleared. Reset mid-operation aborts it; the aborted result never commits.
- Start sampled at edge E0: `busy`=1 in cycles after E0 through E(N−1); at edge EN, `hi`/`lo` take the new value and `busy`=0 simultaneously (N = MULT_CYCLES or DIV_CYCLES).
- Back-to-back: a new `start` is accepted in the first cycle `busy`=0, i.e. it is sampled at E(N+1).
- MTHI/MTLO: new value visible the cycle after the sampling edge.
- `hi`, `lo`, `busy` are direct register outputs; no combinational path from inputs.

## Structure

- `mdu_pkg`: `op` encoding localparams (MDU_NONE … MDU_MTLO) and default cycle constants; shared with the controller decoder.
- Single module, no sub-modules: counter, pending-result registers, HI/LO registers. Multiply and divide are expressed with `*`, `/`, `%` on sign-appropriate 32/64-bit operands.

## Test plan

- MULT a=0xFFFFFFFE (−2), b=3 → busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=−7 (0xFFFFFFF9), b=2 → busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=2 → lo=3, hi=1; DIV 0x80000000 by −1 → lo=0x80000000, hi=0.
- MTHI a=0x12345678 then MTLO a=0x9ABCDEF0 on consecutive cycles → busy never rises; hi/lo hold those values; then DIV by b=0 → busy 10 cycles, hi/lo unchanged.
- MULT 6×7 started, MTLO a=0xDEAD and DIVU pulsed during busy → both ignored; lo=42, hi=0 at commit; new start accepted the first cycle busy=0.
- DIVU started, `reset`=0 asserted on the 4th busy cycle → busy=0, hi=lo=0 after that edge; no later commit.
